// File: rtl/spi_xfer_sequencer.sv
// Drives a memory-mapped SPI core through a full transfer, keeping one byte in flight.
// Each core access is 2 asserted cycles followed by 1 idle cycle.
module spi_xfer_sequencer #(
    parameter logic [15:0] SLAVE_MASK = 16'h0001,
    parameter int          TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_len,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        spi_select,
    output logic [2:0]  mem_addr,
    output logic        write_n,
    output logic        read_n,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu,
    input  logic        readyfordata,
    input  logic        dataavailable,
    output logic [3:0]  state_dbg
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SEL    = 4'd1;
    localparam logic [3:0] S_SSON   = 4'd2;
    localparam logic [3:0] S_GETTX  = 4'd3;
    localparam logic [3:0] S_WRTX   = 4'd4;
    localparam logic [3:0] S_WAITRX = 4'd5;
    localparam logic [3:0] S_RDRX   = 4'd6;
    localparam logic [3:0] S_PUSH   = 4'd7;
    localparam logic [3:0] S_SSOFF  = 4'd8;
    localparam logic [3:0] S_FIN    = 4'd9;

    logic [3:0]    state;
    logic [1:0]    phase;
    logic [8:0]    byte_cnt;
    logic [TW-1:0] to_cnt;
    logic          err_flag;
    logic          tx_held;
    logic [7:0]    tx_byte;

    logic          acc_active;
    logic          acc_write;
    logic          acc_last;
    logic [2:0]    acc_addr;
    logic [15:0]   acc_data;
    logic          unused_hi;

    // Access descriptor for the states that talk to the core; phase 2 is the idle gap.
    always_comb begin
        acc_active = 1'b0;
        acc_write  = 1'b0;
        acc_addr   = 3'd0;
        acc_data   = 16'h0000;
        case (state)
            S_SEL:   begin acc_active = 1'b1; acc_write = 1'b1; acc_addr = 3'd5; acc_data = SLAVE_MASK; end
            S_SSON:  begin acc_active = 1'b1; acc_write = 1'b1; acc_addr = 3'd3; acc_data = 16'h0400; end
            S_WRTX:  begin acc_active = 1'b1; acc_write = 1'b1; acc_addr = 3'd1; acc_data = {8'h00, tx_byte}; end
            S_RDRX:  begin acc_active = 1'b1; acc_write = 1'b0; acc_addr = 3'd0; end
            S_SSOFF: begin acc_active = 1'b1; acc_write = 1'b1; acc_addr = 3'd3; acc_data = 16'h0000; end
            default: ;
        endcase
    end

    assign acc_last      = acc_active && (phase == 2'd2);
    assign spi_select    = acc_active && (phase != 2'd2);
    assign write_n       = !(spi_select && acc_write);
    assign read_n        = !(spi_select && !acc_write);
    assign mem_addr      = spi_select ? acc_addr : 3'd0;
    assign data_from_cpu = spi_select ? acc_data : 16'h0000;

    // Streams transfer on a cycle where valid and ready are both high at the clock edge;
    // valid never waits on ready, and a producer holds its data until the transfer.
    assign req_ready = (state == S_IDLE) && !reset;
    assign tx_ready  = (state == S_GETTX) && !tx_held;
    assign rx_valid  = (state == S_PUSH);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);
    assign err       = done && err_flag;
    assign state_dbg = state;
    assign unused_hi = ^data_to_cpu[15:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            phase    <= 2'd0;
            byte_cnt <= 9'd0;
            to_cnt   <= '0;
            err_flag <= 1'b0;
            tx_held  <= 1'b0;
            tx_byte  <= 8'h00;
            rx_data  <= 8'h00;
        end else begin
            phase <= (acc_active && !acc_last) ? phase + 2'd1 : 2'd0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        byte_cnt <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
                        err_flag <= 1'b0;
                        state    <= S_SEL;
                    end
                end
                S_SEL:  if (acc_last) state <= S_SSON;
                S_SSON: if (acc_last) state <= S_GETTX;
                S_GETTX: begin
                    if (tx_held) begin
                        if (readyfordata) begin
                            tx_held <= 1'b0;
                            state   <= S_WRTX;
                        end
                    end else if (tx_valid) begin
                        tx_byte <= tx_data;
                        if (readyfordata) state <= S_WRTX;
                        else              tx_held <= 1'b1;
                    end
                end
                S_WRTX: begin
                    if (acc_last) begin
                        to_cnt <= '0;
                        state  <= S_WAITRX;
                    end
                end
                S_WAITRX: begin
                    if (dataavailable) begin
                        state <= S_RDRX;
                    end else begin
                        if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
                        if (to_cnt == TO_LAST) begin
                            err_flag <= 1'b1;
                            state    <= S_SSOFF;
                        end
                    end
                end
                S_RDRX: begin
                    if (phase == 2'd1) rx_data <= data_to_cpu[7:0];
                    if (acc_last) state <= S_PUSH;
                end
                S_PUSH: begin
                    if (rx_ready) begin
                        byte_cnt <= byte_cnt - 9'd1;
                        state    <= (byte_cnt == 9'd1) ? S_SSOFF : S_GETTX;
                    end
                end
                S_SSOFF: if (acc_last) state <= S_FIN;
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
